// File: rtl/minesweeper_pkg.sv
// ============================================================================
// minesweeper_pkg
// Shared action codes, action-word layout and handshake state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package minesweeper_pkg;

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_UP     = 3'd1;
  localparam logic [2:0] CODE_DOWN   = 3'd2;
  localparam logic [2:0] CODE_LEFT   = 3'd3;
  localparam logic [2:0] CODE_RIGHT  = 3'd4;
  localparam logic [2:0] CODE_REVEAL = 3'd5;
  localparam logic [2:0] CODE_FLAG   = 3'd6;

  localparam int ACTION_VALID_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RELEASE = 2'd2
  } action_state_t;

  // Lowest-numbered button wins when several presses land together.
  function automatic logic [2:0] press_code(input logic [5:0] presses);
    if (presses[0])      return CODE_UP;
    else if (presses[1]) return CODE_DOWN;
    else if (presses[2]) return CODE_LEFT;
    else if (presses[3]) return CODE_RIGHT;
    else if (presses[4]) return CODE_REVEAL;
    else if (presses[5]) return CODE_FLAG;
    else                 return CODE_NONE;
  endfunction

  function automatic logic [7:0] action_word(input logic [2:0] code);
    logic [7:0] word;
    word = '0;
    word[ACTION_VALID_BIT] = 1'b1;
    word[2:0] = code;
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce
// Two-flop synchroniser, stability-count debouncer and rising-edge press pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce
  import minesweeper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

`default_nettype wire

// File: rtl/action_port.sv
// ============================================================================
// action_port
// Debounced button presses queued and offered to the CPU over an ack handshake.
// Macro ACTION_FIFO_EN: FIFO_DEPTH-entry FIFO; otherwise one holding register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module action_port
  import minesweeper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] BTN,
  input  logic       ack_in,
  output logic [7:0] action,
  output logic       overflow
);

`ifdef ACTION_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  localparam int CAPACITY = FIFO_EN ? FIFO_DEPTH : 1;
  localparam int CW       = $clog2(CAPACITY + 1);

  logic [5:0]    presses;
  logic [2:0]    code;
  logic [2:0]    head;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;
  logic          accept;
  action_state_t state;

  for (genvar i = 0; i < 6; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (CLK),
      .rst    (RESET),
      .btn_raw(BTN[i]),
      .press  (presses[i])
    );
  end

  assign code   = press_code(presses);
  assign push   = (code != CODE_NONE);
  assign full   = (count == CW'(CAPACITY));
  assign pop    = (state == ST_IDLE) && (count != '0) && !ack_in;
  // A pop in the same cycle frees the slot the new code needs.
  assign accept = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept && !pop)      count <= count + CW'(1);
      else if (pop && !accept) count <= count - CW'(1);
      if (push && !accept)     overflow <= 1'b1;
    end
  end

  if (FIFO_EN) begin : g_fifo
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= code;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end

    assign head = mem[rd_ptr];
  end else begin : g_hold
    logic [2:0] hold_code;

    always_ff @(posedge CLK) begin
      if (RESET)       hold_code <= '0;
      else if (accept) hold_code <= code;
    end

    assign head = hold_code;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      action <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            action <= action_word(head);
            state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (ack_in) begin
            action <= 8'h00;
            state  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack_in) state <= ST_IDLE;
        end
        default: begin
          action <= 8'h00;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_action_port.sv
// ============================================================================
// tb_action_port
// Directed and random stimulus against a history-based model of the port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_action_port;

  localparam int N     = 4;
  localparam int DEPTH = 4;
`ifdef ACTION_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic [5:0] btn = 6'd0;
  logic [7:0] action;
  logic       overflow;

  always #5 clk = ~clk;

  action_port #(
    .DEBOUNCE_CYCLES(N),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .BTN     (btn),
    .ack_in  (ack),
    .action  (action),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: raw samples per clock edge; the synchronised value seen
  // at edge j is the sample taken at edge j-2.
  logic [5:0] hist[$];
  bit         rsth[$];
  logic [5:0] lvl  = '0;
  logic [5:0] rose = '0;
  int         mstate = 0;
  logic [7:0] mact = '0;
  bit         movf = 1'b0;
  int         q[$];

  function automatic bit flips(input int k, input int b);
    if (k < N + 1) return 1'b0;
    for (int j = k - N - 1; j <= k; j++) if (rsth[j]) return 1'b0;
    for (int j = k - N + 1; j <= k; j++) if (hist[j-2][b] == lvl[b]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int         k;
    int         code;
    logic [5:0] nr;
    hist.push_back(rst ? 6'd0 : btn);
    rsth.push_back(rst);
    k = hist.size() - 1;
    if (rst) begin
      lvl = '0; rose = '0; mstate = 0; q.delete(); mact = '0; movf = 1'b0;
      return;
    end
    code = 0;
    for (int b = 5; b >= 0; b--) if (rose[b]) code = b + 1;
    if (mstate == 0) begin
      if (q.size() > 0 && !ack) begin
        mact = 8'h80 | 8'(q.pop_front());
        mstate = 1;
      end
    end else if (mstate == 1) begin
      if (ack) begin mact = '0; mstate = 2; end
    end else if (!ack) begin
      mstate = 0;
    end
    if (code != 0) begin
      if (q.size() < CAP) q.push_back(code);
      else movf = 1'b1;
    end
    nr = '0;
    for (int b = 0; b < 6; b++) begin
      if (flips(k, b)) begin
        lvl[b] = ~lvl[b];
        if (lvl[b]) nr[b] = 1'b1;
      end
    end
    rose = nr;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("action", action, mact);
    check("overflow", overflow, movf);
  endtask

  task automatic wait_offer(input string tag, input int exp);
    int n = 0;
    while (action == 8'h00 && n < 60) begin cyc(); n++; end
    check(tag, action, exp);
  endtask

  task automatic do_ack();
    ack = 1'b1; cyc();
    check("ack_clear", action, 0);
    ack = 1'b0; cyc(); cyc();
  endtask

  task automatic quiet(input string tag, input int cycles);
    int extra = 0;
    repeat (cycles) begin cyc(); if (action != 8'h00) extra++; end
    check(tag, extra, 0);
  endtask

  task automatic press_release(input int b);
    btn[b] = 1'b1; repeat (N + 6) cyc();
    btn[b] = 1'b0; repeat (N + 6) cyc();
  endtask

  int ord[6] = '{2, 0, 4, 1, 5, 3};

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    check("reset_action", action, 0);
    check("reset_ovf", overflow, 0);

    // Clean reveal press and full handshake
    btn[4] = 1'b1;
    wait_offer("reveal", 8'h85);
    repeat (5) cyc();
    check("reveal_held", action, 8'h85);
    do_ack();
    btn = '0;
    quiet("after_reveal", 20);

    // Bouncing up button, then held
    for (int i = 0; i < 10; i++) begin btn[0] = ~btn[0]; cyc(); cyc(); end
    btn[0] = 1'b1;
    wait_offer("bounce", 8'h81);
    do_ack();
    quiet("bounce_single", 30);
    btn = '0; repeat (12) cyc();

    // Coincident down and right
    btn = 6'b001010;
    wait_offer("coincide", 8'h82);
    do_ack();
    quiet("coincide_single", 30);
    check("coincide_ovf", overflow, 0);
    btn = '0; repeat (12) cyc();

    // Six presses with no ack, then drain in order
    for (int i = 0; i < 6; i++) press_release(ord[i]);
    check("fill_ovf", overflow, 1);
    for (int i = 0; i <= CAP; i++) begin
      wait_offer("drain", 8'h80 | (ord[i] + 1));
      do_ack();
    end
    quiet("drain_done", 30);

    // Ack stuck high from reset
    rst = 1'b1; ack = 1'b1; cyc(); cyc();
    rst = 1'b0;
    btn[5] = 1'b1;
    repeat (25) cyc();
    check("stuck_ack", action, 0);
    ack = 1'b0;
    wait_offer("flag", 8'h86);
    do_ack();
    btn = '0; repeat (12) cyc();

    // Reset while offering, held button re-debounced afterwards
    btn[2] = 1'b1;
    wait_offer("pre_rst", 8'h83);
    rst = 1'b1; cyc();
    check("rst_action", action, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    wait_offer("repress", 8'h83);
    do_ack();
    btn = '0; repeat (12) cyc();

    // Random buttons, ack and occasional reset
    repeat (3000) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 4) == 0) ack = ~ack;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
